// File: rtl/grad_weight_update.sv
// Gradient-descent weight register: subtracts capped Q8.8 steps from a Q24.8 weight with saturation,
// ending a run on convergence streak or iteration limit. Optional macro GWU_CAP_COUNT_EN adds cap_count.
module grad_weight_update #(
    parameter int unsigned MAX_ITER    = 1024,
    parameter logic [15:0] CONV_THRESH = 16'h0004,
    parameter int unsigned CONV_COUNT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] w_init,
    input  logic        step_valid,
    output logic        step_ready,
    input  logic [15:0] step_in,
    input  logic        step_ovf,
    input  logic        step_unf,
    output logic [31:0] w_out,
    output logic        w_valid,
    output logic        busy,
    output logic        done,
    output logic        converged,
    output logic [15:0] iter_count
`ifdef GWU_CAP_COUNT_EN
    ,
    output logic [15:0] cap_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         streak_q;
    logic               accept;
    logic               converging;
    logic               streak_hit;
    logic               iter_hit;
    logic [16:0]        step_mag;
    logic signed [32:0] diff;
    logic [31:0]        w_next;

    assign accept = step_valid && step_ready;

    // Step magnitude needs 17 bits so that the most negative step maps to +32768.
    always_comb begin
        step_mag   = step_in[15] ? (17'd0 - {1'b1, step_in}) : {1'b0, step_in};
        converging = (step_mag <= {1'b0, CONV_THRESH}) && !step_ovf && !step_unf;
        streak_hit = converging && (({1'b0, streak_q} + 9'd1) == 9'(CONV_COUNT));
        iter_hit   = ({1'b0, iter_count} + 17'd1) == 17'(MAX_ITER);
        diff       = $signed({w_out[31], w_out}) - $signed({{17{step_in[15]}}, step_in});
        if (diff[32] != diff[31]) begin
            w_next = diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            w_next = diff[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if ((state_q == RUN) && accept && (streak_hit || iter_hit)) begin
            state_d = DONE;
        end
    end

    always_comb begin
        step_ready = (state_q == RUN) && !start;
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
    end

    // Convergence wins when both end conditions land on the same step.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_out      <= 32'd0;
            w_valid    <= 1'b0;
            iter_count <= 16'd0;
            streak_q   <= 8'd0;
            converged  <= 1'b0;
        end else if (start) begin
            w_out      <= w_init;
            w_valid    <= 1'b0;
            iter_count <= 16'd0;
            streak_q   <= 8'd0;
            converged  <= 1'b0;
        end else if (accept) begin
            w_out      <= w_next;
            w_valid    <= 1'b1;
            iter_count <= iter_count + 16'd1;
            streak_q   <= converging ? (streak_q + 8'd1) : 8'd0;
            if (streak_hit) begin
                converged <= 1'b1;
            end
        end else begin
            w_valid <= 1'b0;
        end
    end

`ifdef GWU_CAP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || start) begin
            cap_count <= 16'd0;
        end else if (accept && (step_ovf || step_unf) && (cap_count != 16'hFFFF)) begin
            cap_count <= cap_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_grad_weight_update.sv
// Scoreboard bench for grad_weight_update: two instances (default and MAX_ITER=4) share one
// randomized/directed stimulus stream and are checked against an arithmetic reference model.
module tb_grad_weight_update;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    typedef struct {
        int     fsm;
        longint w;
        int     iter;
        int     streak;
        bit     conv;
        int     cap;
        bit     wv;
    } model_t;

    typedef struct {
        logic [31:0] w;
        logic [15:0] iter;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] w_init = 32'd0;
    logic        step_valid = 1'b0;
    logic [15:0] step_in = 16'd0;
    logic        step_ovf = 1'b0;
    logic        step_unf = 1'b0;

    logic        step_ready_a, w_valid_a, busy_a, done_a, converged_a;
    logic [31:0] w_out_a;
    logic [15:0] iter_count_a;
    logic        step_ready_b, w_valid_b, busy_b, done_b, converged_b;
    logic [31:0] w_out_b;
    logic [15:0] iter_count_b;
`ifdef GWU_CAP_COUNT_EN
    logic [15:0] cap_count_a;
    logic [15:0] cap_count_b;
`endif

    int     nChecks = 0;
    int     nFails  = 0;
    model_t ma;
    model_t mb;
    sb_t    qa[$];
    sb_t    qb[$];

    grad_weight_update dut_a (
        .clk(clk), .rst(rst), .start(start), .w_init(w_init),
        .step_valid(step_valid), .step_ready(step_ready_a), .step_in(step_in),
        .step_ovf(step_ovf), .step_unf(step_unf), .w_out(w_out_a), .w_valid(w_valid_a),
        .busy(busy_a), .done(done_a), .converged(converged_a), .iter_count(iter_count_a)
`ifdef GWU_CAP_COUNT_EN
        , .cap_count(cap_count_a)
`endif
    );

    grad_weight_update #(.MAX_ITER(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .w_init(w_init),
        .step_valid(step_valid), .step_ready(step_ready_b), .step_in(step_in),
        .step_ovf(step_ovf), .step_unf(step_unf), .w_out(w_out_b), .w_valid(w_valid_b),
        .busy(busy_b), .done(done_b), .converged(converged_b), .iter_count(iter_count_b)
`ifdef GWU_CAP_COUNT_EN
        , .cap_count(cap_count_b)
`endif
    );

    always #5 clk = ~clk;

    // Reference behaviour: plain integer arithmetic with explicit clamping to the 32-bit range.
    function automatic model_t modelNext(model_t m, int maxIter, bit r, bit s, logic [31:0] wi,
                                         bit v, logic [15:0] stp, bit o, bit u);
        model_t n;
        longint sv;
        longint mag;
        n = m;
        n.wv = 1'b0;
        if (r) begin
            n = '{default: 0};
        end else if (s) begin
            n.fsm    = M_RUN;
            n.w      = longint'($signed(wi));
            n.iter   = 0;
            n.streak = 0;
            n.conv   = 1'b0;
            n.cap    = 0;
        end else if (m.fsm == M_RUN && v) begin
            sv  = longint'($signed(stp));
            n.w = m.w - sv;
            if (n.w > 64'sd2147483647) n.w = 64'sd2147483647;
            if (n.w < -64'sd2147483648) n.w = -64'sd2147483648;
            n.iter = m.iter + 1;
            mag = (sv < 0) ? -sv : sv;
            if (mag <= 4 && !o && !u) n.streak = m.streak + 1;
            else n.streak = 0;
            if (o || u) n.cap = (m.cap == 65535) ? 65535 : m.cap + 1;
            n.wv = 1'b1;
            if (n.streak == 8) begin
                n.fsm  = M_DONE;
                n.conv = 1'b1;
            end else if (n.iter == maxIter) begin
                n.fsm = M_DONE;
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkState(input string tag, input model_t m, input logic [31:0] w, input logic wv,
                              input logic b, input logic d, input logic c, input logic [15:0] it);
        checkOutput({tag, "_w_out"}, w, 32'(m.w));
        checkOutput({tag, "_w_valid"}, 32'(wv), 32'(m.wv));
        checkOutput({tag, "_busy"}, 32'(b), 32'(m.fsm == M_RUN));
        checkOutput({tag, "_done"}, 32'(d), 32'(m.fsm == M_DONE));
        checkOutput({tag, "_converged"}, 32'(c), 32'(m.conv));
        checkOutput({tag, "_iter"}, 32'(it), 32'(m.iter));
    endtask

    // One clock of stimulus: drive at negedge, check ready, advance model at posedge, check state.
    task automatic applyStimulus(input bit r, input bit s, input logic [31:0] wi, input bit v,
                                 input logic [15:0] stp, input bit o, input bit u);
        @(negedge clk);
        rst = r; start = s; w_init = wi; step_valid = v; step_in = stp; step_ovf = o; step_unf = u;
        #1;
        checkOutput("ready_a", 32'(step_ready_a), 32'(ma.fsm == M_RUN && !s));
        checkOutput("ready_b", 32'(step_ready_b), 32'(mb.fsm == M_RUN && !s));
        @(posedge clk);
        ma = modelNext(ma, 1024, r, s, wi, v, stp, o, u);
        mb = modelNext(mb, 4, r, s, wi, v, stp, o, u);
        if (ma.wv) qa.push_back('{w: 32'(ma.w), iter: 16'(ma.iter)});
        if (mb.wv) qb.push_back('{w: 32'(mb.w), iter: 16'(mb.iter)});
        #1;
        checkState("a", ma, w_out_a, w_valid_a, busy_a, done_a, converged_a, iter_count_a);
        checkState("b", mb, w_out_b, w_valid_b, busy_b, done_b, converged_b, iter_count_b);
`ifdef GWU_CAP_COUNT_EN
        checkOutput("cap_a", 32'(cap_count_a), 32'(ma.cap));
        checkOutput("cap_b", 32'(cap_count_b), 32'(mb.cap));
`endif
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 32'd0, 0, 16'd0, 0, 0);
    endtask

    task automatic runDirected();
        applyStimulus(1, 0, 32'd0, 0, 16'd0, 0, 0);
        checkOutput("rst_w_out", w_out_a, 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);

        applyStimulus(0, 1, 32'h0000_0A00, 0, 16'd0, 0, 0);
        applyStimulus(0, 0, 32'd0, 1, 16'h0100, 0, 0);
        checkOutput("basic_w_out", w_out_a, 32'h0000_0900);
        checkOutput("basic_w_valid", 32'(w_valid_a), 32'd1);
        checkOutput("basic_iter", 32'(iter_count_a), 32'd1);
        applyStimulus(0, 0, 32'd0, 0, 16'd0, 0, 0);
        checkOutput("basic_w_valid_drop", 32'(w_valid_a), 32'd0);

        applyStimulus(0, 1, 32'h7FFF_FF00, 0, 16'd0, 0, 0);
        applyStimulus(0, 0, 32'd0, 1, 16'h0002, 0, 0);
        applyStimulus(0, 0, 32'd0, 1, 16'h8000, 0, 1);
        checkOutput("sat_w_out", w_out_a, 32'h7FFF_FFFF);
`ifdef GWU_CAP_COUNT_EN
        checkOutput("sat_cap", 32'(cap_count_a), 32'd1);
`endif
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 32'd0, 1, 16'h0002, 0, 0);
        checkOutput("sat_streak_cleared_busy", 32'(busy_a), 32'd1);

        applyStimulus(0, 1, 32'd0, 0, 16'd0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 32'd0, 1, 16'h0002, 0, 0);
        checkOutput("conv_done", 32'(done_a), 32'd1);
        checkOutput("conv_converged", 32'(converged_a), 32'd1);
        checkOutput("conv_iter", 32'(iter_count_a), 32'd8);
        checkOutput("conv_ready", 32'(step_ready_a), 32'd0);

        applyStimulus(0, 1, 32'h0000_1000, 0, 16'd0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 32'd0, 1, 16'h0100, 0, 0);
        checkOutput("maxit_done", 32'(done_b), 32'd1);
        checkOutput("maxit_converged", 32'(converged_b), 32'd0);
        checkOutput("maxit_iter", 32'(iter_count_b), 32'd4);
        checkOutput("maxit_w_out", w_out_b, 32'h0000_0C00);
        checkOutput("maxit_no_5th", 32'(w_valid_b), 32'd0);

        applyStimulus(0, 1, 32'h0000_5000, 0, 16'd0, 0, 0);
        applyStimulus(0, 0, 32'd0, 1, 16'h0100, 0, 0);
        applyStimulus(0, 0, 32'd0, 1, 16'h0100, 0, 0);
        applyStimulus(0, 1, 32'h0000_5000, 1, 16'h0100, 0, 0);
        checkOutput("restart_w_out", w_out_a, 32'h0000_5000);
        checkOutput("restart_iter", 32'(iter_count_a), 32'd0);

        applyStimulus(0, 0, 32'd0, 1, 16'h0100, 0, 0);
        applyStimulus(1, 0, 32'd0, 1, 16'h0100, 1, 0);
        checkOutput("midrst_w_out", w_out_a, 32'd0);
        checkOutput("midrst_w_valid", 32'(w_valid_a), 32'd0);
        checkOutput("midrst_busy", 32'(busy_a), 32'd0);
        checkOutput("midrst_iter", 32'(iter_count_a), 32'd0);
    endtask

    task automatic runRandom(input int cycles);
        bit          r, s, v, o, u;
        logic [31:0] wi;
        logic [15:0] stp;
        for (int i = 0; i < cycles; i++) begin
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 99) < 5);
            v = ($urandom_range(0, 99) < 75);
            o = ($urandom_range(0, 9) == 0);
            u = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: wi = 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
                1: wi = 32'h8000_FFFF - 32'($urandom_range(0, 65535));
                default: wi = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0, 1: stp = 16'($signed($urandom_range(0, 10)) - 5);
                2: stp = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
                default: stp = 16'($urandom);
            endcase
            applyStimulus(r, s, wi, v, stp, o, u);
        end
    endtask

    // Scoreboard monitor: every w_valid pulse must match the oldest expected update.
    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (w_valid_a === 1'b1) begin
                if (qa.size() == 0) begin
                    nChecks++; nFails++;
                    $display("[TB] FAIL sb_a_unexpected actual=w_valid expected=none at %0t", $time);
                end else begin
                    e = qa.pop_front();
                    checkOutput("sb_a_w_out", w_out_a, e.w);
                    checkOutput("sb_a_iter", 32'(iter_count_a), 32'(e.iter));
                end
            end
            if (w_valid_b === 1'b1) begin
                if (qb.size() == 0) begin
                    nChecks++; nFails++;
                    $display("[TB] FAIL sb_b_unexpected actual=w_valid expected=none at %0t", $time);
                end else begin
                    e = qb.pop_front();
                    checkOutput("sb_b_w_out", w_out_b, e.w);
                    checkOutput("sb_b_iter", 32'(iter_count_b), 32'(e.iter));
                end
            end
        end
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        fork
            begin
                runDirected();
                runRandom(600);
                idleCycles(3);
                checkOutput("sb_a_drained", 32'(qa.size()), 32'd0);
                checkOutput("sb_b_drained", 32'(qb.size()), 32'd0);
            end
            monitor();
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/grad_weight_update.md
GRAD_WEIGHT_UPDATE -- requirements
Module: grad_weight_update

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL provide parameter MAX_ITER, default 1024, the iteration limit (1..65535).
REQ-003 The block SHALL provide parameter CONV_THRESH, default 16'h0004, the Q8.8 magnitude at or below which a step counts as converging.
REQ-004 The block SHALL provide parameter CONV_COUNT, default 8, the number of consecutive converging steps that ends a run (1..255).
REQ-005 Ports SHALL be exactly as follows:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin or restart a run
- w_init  in  32  initial weight, signed Q24.8
- step_valid  in  1  step_in is valid
- step_ready  out  1  block accepts a step this cycle
- step_in  in  16  signed Q8.8 step (lr*grad) from the capped multiplier
- step_ovf  in  1  multiplier positive-cap flag, qualified by step_valid
- step_unf  in  1  multiplier negative-cap flag, qualified by step_valid
- w_out  out  32  current weight, signed Q24.8
- w_valid  out  1  one-cycle pulse: w_out updated
- busy  out  1  state is RUN
- done  out  1  state is DONE
- converged  out  1  last run ended by convergence
- iter_count  out  16  steps accepted in the current run
- cap_count  out  16  capped steps accepted in the current run (CAP_COUNT_EN only)

Function
REQ-006 The FSM SHALL have three states, IDLE, RUN and DONE; it SHALL enter IDLE on reset.
REQ-007 A start in any state SHALL load w_out<=w_init, clear iter_count, the streak counter, converged and cap_count, and enter RUN on the next edge.
REQ-008 step_ready SHALL be (state==RUN) AND NOT start, driven combinationally.
REQ-009 A step SHALL be accepted when step_valid and step_ready are both high in the same cycle.
REQ-010 On acceptance, the block SHALL sign-extend step_in to 32 bits (same 8 fraction bits).
REQ-011 On acceptance, the block SHALL compute w_out minus step at 33-bit width.
REQ-012 The subtraction result SHALL saturate to 32'h7FFFFFFF or 32'h80000000.
REQ-013 The result SHALL be registered into w_out on the next edge.
REQ-014 w_valid SHALL pulse high for exactly one cycle after each accepted step; latency is 1 cycle and throughput is 1 step per cycle.
REQ-015 On each accepted step, iter_count SHALL increment by 1.
REQ-016 The step magnitude |step_in| SHALL be computed at 17 bits, so that 16'h8000 gives 32768.
REQ-017 A step SHALL count as converging when |step_in| <= CONV_THRESH and step_ovf and step_unf are both 0.
REQ-018 A converging step SHALL increment the streak counter; any other step SHALL clear it.
REQ-019 When the streak counter reaches CONV_COUNT, the FSM SHALL move from RUN to DONE and set converged=1.
REQ-020 When iter_count reaches MAX_ITER, the FSM SHALL move from RUN to DONE with converged=0.
REQ-021 If both end conditions occur on the same step, converged SHALL be 1.
REQ-022 In DONE, w_out, iter_count and converged SHALL hold, and step_ready SHALL be 0; only start leaves DONE.
REQ-023 In IDLE, step_valid SHALL be ignored and all outputs SHALL hold.

Reset
REQ-024 Reset SHALL take priority over start and over any step.
REQ-025 On reset the block SHALL set: state=IDLE, w_out=0, w_valid=0, iter_count=0, streak=0, converged=0, cap_count=0, busy=0, done=0.
REQ-026 Reset asserted mid-RUN SHALL discard any step presented in that cycle.

Configuration
REQ-027 When macro GWU_CAP_COUNT_EN is defined, port cap_count SHALL exist.
REQ-028 With GWU_CAP_COUNT_EN defined, cap_count SHALL increment, saturating at 16'hFFFF, on each accepted step with step_ovf or step_unf high.
REQ-029 When GWU_CAP_COUNT_EN is undefined, port cap_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Bench SHALL cover: w_init=32'h00000A00, start, one step 16'h0100 -> next cycle w_out=32'h00000900, w_valid pulse, iter_count=1.
REQ-031 Bench SHALL cover: w_init=32'h7FFFFF00, step 16'h8000 (with step_unf=1) -> w_out=32'h7FFFFFFF, streak cleared, cap_count=1 if enabled.
REQ-032 Bench SHALL cover: 8 consecutive steps 16'h0002 with defaults -> done=1 and converged=1 after the 8th, iter_count=8, step_ready=0.
REQ-033 Bench SHALL cover: MAX_ITER=4, steps 16'h0100 x4 -> done=1, converged=0, iter_count=4; the 5th step_valid is not accepted.
REQ-034 Bench SHALL cover: start asserted mid-RUN together with step_valid -> step_ready=0 that cycle, w_out=w_init next cycle, iter_count=0.
REQ-035 Bench SHALL cover: rst pulsed mid-RUN with a valid step -> every output is at its reset value next cycle, and no w_valid pulse occurs.
